// File: rtl/branch_pkg.sv
// Shared funct3 codes, stage payload type and branch decode for the branch
// condition pipeline.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef struct packed {
    logic breq;
    logic brlt;
    logic taken;
    logic illegal;
  } branch_res_t;

  // funct3 010/011 are not branches: never taken, flagged illegal.
  function automatic branch_res_t branch_resolve(logic [2:0] f3, logic eq, logic lt);
    branch_res_t r;
    r.breq    = eq;
    r.brlt    = lt;
    r.illegal = 1'b0;
    case (f3)
      BEQ:         r.taken = eq;
      BNE:         r.taken = ~eq;
      BLT, BLTU:   r.taken = lt;
      BGE, BGEU:   r.taken = ~lt;
      default: begin
        r.taken   = 1'b0;
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_half_cmp.sv
// Combinational equality / less-than of a W-bit slice; is_signed treats the
// slice MSB as a sign bit.
module branch_half_cmp #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_signed,
  output logic         eq,
  output logic         lt
);

  always_comb begin
    eq = (a == b);
    if (is_signed && (a[W-1] != b[W-1]))
      lt = a[W-1];
    else
      lt = (a < b);
  end

endmodule

// File: rtl/branch_cond_pipe.sv
// RISC-V branch condition resolver, 1- or 2-stage valid/ready pipeline.
// Define BRANCH_COND_STATS_EN to add resolved_count / taken_count outputs.
module branch_cond_pipe
  import branch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            breq,
  output logic            brlt,
  output logic            taken,
  output logic            illegal
`ifdef BRANCH_COND_STATS_EN
  ,
  output logic [31:0]     resolved_count,
  output logic [31:0]     taken_count
`endif
);

  localparam int H = XLEN / 2;

  logic        load_out;
  branch_res_t res_c;
  logic        vld_p1;
  branch_res_t res_p1;

  if ((XLEN < 8) || (XLEN % 2 != 0)) begin : g_bad_xlen
    $error("branch_cond_pipe: XLEN must be even and >= 8");
  end

  if (STAGES == 2) begin : g_two
    logic         eq_lo_c, lt_lo_c, eq_hi_c, lt_hi_c;
    logic         vld_p0, eq_lo_p0, lt_lo_p0;
    logic [H-1:0] rs1_hi_p0, rs2_hi_p0;
    logic [2:0]   funct3_p0;
    logic         adv_p0;
    logic         acc_p0;

    // The low halves are always compared unsigned; sign only matters in the top half.
    branch_half_cmp #(.W(H)) u_lo (
      .a(rs1_data[H-1:0]), .b(rs2_data[H-1:0]), .is_signed(1'b0),
      .eq(eq_lo_c), .lt(lt_lo_c)
    );

    assign adv_p0   = vld_p0 & (~vld_p1 | out_ready);
    assign in_ready = ~vld_p0 | adv_p0;
    assign acc_p0   = in_valid & in_ready;

    always_ff @(posedge clk) begin
      if (!rst_n)          vld_p0 <= 1'b0;
      else if (flush)      vld_p0 <= 1'b0;
      else if (acc_p0)     vld_p0 <= 1'b1;
      else if (adv_p0)     vld_p0 <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (acc_p0) begin
        eq_lo_p0  <= eq_lo_c;
        lt_lo_p0  <= lt_lo_c;
        rs1_hi_p0 <= rs1_data[XLEN-1:H];
        rs2_hi_p0 <= rs2_data[XLEN-1:H];
        funct3_p0 <= funct3;
      end
    end

    // ---- stage 1 -> stage 2 ----
    branch_half_cmp #(.W(H)) u_hi (
      .a(rs1_hi_p0), .b(rs2_hi_p0), .is_signed(~funct3_p0[1]),
      .eq(eq_hi_c), .lt(lt_hi_c)
    );

    assign res_c    = branch_resolve(funct3_p0, eq_hi_c & eq_lo_p0,
                                     lt_hi_c | (eq_hi_c & lt_lo_p0));
    assign load_out = adv_p0;
  end else if (STAGES == 1) begin : g_one
    logic eq_c, lt_c;

    branch_half_cmp #(.W(XLEN)) u_full (
      .a(rs1_data), .b(rs2_data), .is_signed(~funct3[1]),
      .eq(eq_c), .lt(lt_c)
    );

    assign in_ready = ~vld_p1 | out_ready;
    assign res_c    = branch_resolve(funct3, eq_c, lt_c);
    assign load_out = in_valid & in_ready;
  end else begin : g_bad_stages
    $error("branch_cond_pipe: STAGES must be 1 or 2");
    assign in_ready = 1'b0;
    assign res_c    = '0;
    assign load_out = 1'b0;
  end

  // ---- output stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load_out) begin
      vld_p1 <= 1'b1;
      res_p1 <= res_c;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign breq      = res_p1.breq;
  assign brlt      = res_p1.brlt;
  assign taken     = res_p1.taken;
  assign illegal   = res_p1.illegal;

`ifdef BRANCH_COND_STATS_EN
  // Counters track consumer handshakes only, so flush never touches them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolved_count <= '0;
      taken_count    <= '0;
    end else if (vld_p1 && out_ready) begin
      resolved_count <= resolved_count + 32'd1;
      if (res_p1.taken)
        taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_cond_pipe.sv
// Scoreboard bench for branch_cond_pipe (XLEN=32, STAGES=2): directed vectors
// followed by randomized traffic with flushes and resets.
module tb_branch_cond_pipe;

  localparam int XLEN   = 32;
  localparam int STAGES = 2;

  typedef struct packed {
    logic breq;
    logic brlt;
    logic taken;
    logic illegal;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [2:0]      funct3 = 3'b000;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            breq, brlt, taken, illegal;
`ifdef BRANCH_COND_STATS_EN
  logic [31:0]     resolved_count, taken_count;
  int unsigned     m_resolved = 0;
  int unsigned     m_taken = 0;
`endif

  branch_cond_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .funct3(funct3), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .breq(breq), .brlt(brlt), .taken(taken), .illegal(illegal)
`ifdef BRANCH_COND_STATS_EN
    , .resolved_count(resolved_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: straight from the branch rules using language-level comparisons.
  function automatic exp_t model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [2:0] f3);
    exp_t e;
    e.breq    = (a == b);
    e.brlt    = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    e.illegal = 1'b0;
    case (f3)
      3'd0:       e.taken = e.breq;
      3'd1:       e.taken = !e.breq;
      3'd4, 3'd6: e.taken = e.brlt;
      3'd5, 3'd7: e.taken = !e.brlt;
      default: begin
        e.taken   = 1'b0;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Stimulus side: push expectation on acceptance, drop in-flight on flush/reset.
  always @(negedge clk) begin
    #1;
    if (!rst_n || flush)
      sb.delete();
    else if (in_valid && in_ready)
      sb.push_back(model(rs1_data, rs2_data, funct3));
  end

  // Output monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", 32'({breq, brlt, taken, illegal}), 32'(e));
      end
    end
`ifdef BRANCH_COND_STATS_EN
    if (!rst_n) begin
      m_resolved = 0;
      m_taken = 0;
    end else if (out_valid && out_ready) begin
      m_resolved++;
      if (taken) m_taken++;
    end
`endif
  end

  // Stall stability and post-reset state.
  logic p_hold = 1'b0;
  logic p_rst  = 1'b0;
  exp_t p_res;
  always @(negedge clk) begin
    if (p_hold)
      check("stall_hold", 32'({out_valid, breq, brlt, taken, illegal}), 32'({1'b1, p_res}));
    if (p_rst) begin
      check("post_reset_in_ready", 32'(in_ready), 32'd1);
      check("post_reset_out_valid", 32'(out_valid), 32'd0);
    end
    p_hold = rst_n && out_valid && !out_ready && !flush;
    p_rst  = !rst_n;
    p_res  = {breq, brlt, taken, illegal};
  end

  // Single directed transaction on an empty pipe with out_ready high.
  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic [3:0] req);
    int t0;
    int n;
    @(posedge clk); #1;
    rs1_data = a; rs2_data = b; funct3 = f3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({name, "_latency"}, 32'(cyc - t0), 32'(STAGES));
    check({name, "_out"}, 32'({breq, brlt, taken, illegal}), 32'(req));
  endtask

  initial begin
    int m;
    logic [31:0] a, b;
    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", 32'({breq, brlt, taken, illegal}), 32'd0);
    rst_n = 1'b1;

    directed("beq_blt_1_2",  32'd1,          32'd2,          3'b100, 4'b0110);
    directed("bne_3_3",      32'd3,          32'd3,          3'b001, 4'b1000);
    directed("blt_neg",      32'hFFFF_FFFD,  32'd3,          3'b100, 4'b0110);
    directed("bltu_neg",     32'hFFFF_FFFD,  32'd3,          3'b110, 4'b0000);
    directed("bgeu_hi",      32'h0001_0000,  32'h0000_FFFF,  3'b111, 4'b0010);
    directed("illegal_010",  32'd5,          32'd5,          3'b010, 4'b1001);

    // Fill with out_ready low, observe backpressure, then flush.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rs1_data = 32'(i); rs2_data = 32'd1; funct3 = 3'b000; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_flush_out_valid", 32'(out_valid), 32'd0);
    end
    directed("after_flush", 32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 4'b0100);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 149) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = $urandom;
      m = $urandom_range(0, 5);
      case (m)
        1: b = a;
        2: b = {a[31:16], b[15:0]};
        3: b = {b[31:16], a[15:0]};
        4: begin
          a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
        end
        default: ;
      endcase
      rs1_data = a;
      rs2_data = b;
      funct3   = 3'($urandom_range(0, 7));
    end

    // Drain.
    @(posedge clk); #1;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
`ifdef BRANCH_COND_STATS_EN
    check("resolved_count", resolved_count, 32'(m_resolved));
    check("taken_count", taken_count, 32'(m_taken));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_cond_pipe.md
BRANCH_COND_PIPE -- requirements
Module: branch_cond_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand width in bits; SHALL be even and >= 8.
REQ-002 Parameter STAGES, default 2, pipeline depth; SHALL accept 1 or 2 only, and elaboration SHALL fail on any other value.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 Port in_valid, input, 1, operand set present.
REQ-006 Port in_ready, output, 1, block accepts the operand set this cycle.
REQ-007 Port rs1_data, input, XLEN, first operand.
REQ-008 Port rs2_data, input, XLEN, second operand.
REQ-009 Port funct3, input, 3, RISC-V branch funct3 code.
REQ-010 Port flush, input, 1, kill all in-flight entries.
REQ-011 Port out_valid, output, 1, result present.
REQ-012 Port out_ready, input, 1, consumer accepts the result.
REQ-013 Port breq, output, 1, operands equal.
REQ-014 Port brlt, output, 1, rs1 < rs2; signed for funct3[1]=0, unsigned for funct3[1]=1.
REQ-015 Port taken, output, 1, branch condition true.
REQ-016 Port illegal, output, 1, funct3 is 010 or 011.

Function
REQ-017 Decode: 000 BEQ taken=breq; 001 BNE taken=~breq; 100 BLT taken=brlt; 101 BGE taken=~brlt; 110 BLTU taken=brlt; 111 BGEU taken=~brlt; 010/011 taken=0, illegal=1.
REQ-018 Signed compare: MSB differs -> brlt = rs1 MSB; otherwise unsigned compare of the full operand.
REQ-019 STAGES=2, stage 1: register eq_lo and lt_lo (unsigned) of the lower XLEN/2 bits, the upper halves of both operands, and funct3.
REQ-020 STAGES=2, stage 2: breq = eq_hi & eq_lo; brlt = lt_hi | (eq_hi & lt_lo), with the signed rule applied to the upper half only.
REQ-021 STAGES=1: full compare and decode in a single registered stage.
REQ-022 Latency: a result SHALL become out_valid exactly STAGES cycles after acceptance when out_ready is held high.
REQ-023 Acceptance occurs on the cycle where in_valid & in_ready.
REQ-024 Each stage advances when the next stage is empty or is advancing; the last stage advances on out_ready.
REQ-025 in_ready = ~stage1_valid | stage1_advances; combinational, with no dependency on in_valid.
REQ-026 Full pipeline with out_ready=0: hold all stages; in_ready=0; outputs stable.
REQ-027 Throughput: one result per cycle while out_ready=1.
REQ-028 Data outputs are valid only while out_valid=1; they hold their last value otherwise.
REQ-029 flush clears every stage-valid bit on the next edge and takes priority over acceptance in the same cycle; in_ready is unaffected by flush.

Reset
REQ-030 While rst_n=0 at a clock edge: all valid bits = 0, and breq, brlt, taken and illegal = 0.
REQ-031 Reset mid-operation SHALL discard in-flight entries, and no result from before reset SHALL appear.
REQ-032 in_ready = 1 on the first cycle after rst_n rises.

Configuration
REQ-033 Macro BRANCH_COND_STATS_EN defined: add outputs resolved_count[31:0] and taken_count[31:0].
REQ-034 resolved_count increments per out_valid & out_ready handshake; taken_count increments when that handshake also has taken=1.
REQ-035 Illegal results count as resolved and not as taken.
REQ-036 Both counters wrap 0xFFFFFFFF -> 0, reset to 0, and are unaffected by flush.
REQ-037 Macro undefined: the counter ports and logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-038 Shared package branch_pkg SHALL hold the funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the stage payload struct typedef.
REQ-039 Sub-module branch_half_cmp(W): combinational eq/lt of a W-bit slice with a signed input; instantiated once for STAGES=1 and twice for STAGES=2.

Verification
REQ-040 rs1=1, rs2=2, funct3=100, XLEN=32 -> breq=0, brlt=1, taken=1 at cycle 2.
REQ-041 rs1=3, rs2=3, funct3=001 -> breq=1, brlt=0, taken=0.
REQ-042 rs1=0xFFFFFFFD, rs2=3: funct3=100 -> taken=1; funct3=110 -> taken=0 and brlt=0.
REQ-043 rs1=0x00010000, rs2=0x0000FFFF, funct3=111 (low halves differ, high decides) -> brlt=0, taken=1.
REQ-044 Three back-to-back inputs, out_ready=0 for 4 cycles, then flush -> in_ready=0 while full; no out_valid after flush; next input emerges 2 cycles after acceptance.
REQ-045 funct3=010 -> illegal=1, taken=0; with BRANCH_COND_STATS_EN, resolved_count=1 and taken_count=0.
